// File: rtl/eth_swap_pkg.sv
// rtl/eth_swap_pkg.sv - shared state encoding, MAC byte offsets and word record for eth_mac_swap_64
package eth_swap_pkg;

    localparam int DATA_W  = 64;
    localparam int KEEP_W  = 8;
    localparam int DST_OFS = 0;
    localparam int SRC_OFS = 6;
    localparam int MAC_LEN = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR1 = 2'd1,
        BODY = 2'd2
    } swap_state_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
        logic              user;
    } swap_word_t;

    // Frame byte position that supplies output byte f once dst and src are exchanged.
    function automatic int swap_map(input int f);
        if (f >= SRC_OFS && f < SRC_OFS + MAC_LEN)
            return f - SRC_OFS + DST_OFS;
        else if (f >= DST_OFS && f < DST_OFS + MAC_LEN)
            return f - DST_OFS + SRC_OFS;
        else
            return f;
    endfunction

endpackage

// File: rtl/eth_mac_swap_64_if.sv
// rtl/eth_mac_swap_64_if.sv - 64-bit AXI-stream bundle with master/slave views
interface eth_mac_swap_64_if;
    import eth_swap_pkg::*;

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);

endinterface

// File: rtl/eth_mac_swap_bytes.sv
// rtl/eth_mac_swap_bytes.sv - combinational remap of the first two words so dst and src MAC trade places
module eth_mac_swap_bytes
    import eth_swap_pkg::*;
#(
    parameter int ENABLE_SWAP = 1
) (
    input  logic [DATA_W-1:0] w0_i,
    input  logic [DATA_W-1:0] w1_i,
    output logic [DATA_W-1:0] out0_o,
    output logic [DATA_W-1:0] out1_o
);

    logic [2*DATA_W-1:0] in_cat;
    logic [2*DATA_W-1:0] out_cat;

    always_comb begin
        in_cat  = {w1_i, w0_i};
        out_cat = in_cat;
        if (ENABLE_SWAP != 0) begin
            for (int f = 0; f < 2 * KEEP_W; f++) begin
                out_cat[8*f +: 8] = in_cat[8*swap_map(f) +: 8];
            end
        end
    end

    assign out0_o = out_cat[DATA_W-1:0];
    assign out1_o = out_cat[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/eth_mac_swap_64.sv
// rtl/eth_mac_swap_64.sv - 64-bit streaming dst/src MAC swapper; ETH_MAC_SWAP_CNT_EN adds frame/short counters
module eth_mac_swap_64
    import eth_swap_pkg::*;
#(
    parameter int ENABLE_SWAP = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    eth_mac_swap_64_if.slave   input_axis,
    eth_mac_swap_64_if.master  output_axis
`ifdef ETH_MAC_SWAP_CNT_EN
    ,
    output logic [31:0]        frame_count,
    output logic [15:0]        short_count
`endif
);

    swap_state_t state_q;
    swap_word_t  h_q;
    swap_word_t  o_q;

    logic              slot_free;
    logic              accept;
    logic              hdr_ok;
    logic [DATA_W-1:0] swp_w0;
    logic [DATA_W-1:0] swp_w1;

    assign slot_free         = !o_q.valid || output_axis.tready;
    assign input_axis.tready = slot_free;
    assign accept            = input_axis.tvalid && slot_free;
    assign hdr_ok            = (input_axis.tkeep[3:0] == 4'hF);

    eth_mac_swap_bytes #(
        .ENABLE_SWAP (ENABLE_SWAP)
    ) u_bytes (
        .w0_i   (h_q.data),
        .w1_i   (input_axis.tdata),
        .out0_o (swp_w0),
        .out1_o (swp_w1)
    );

    // H holds original data one word behind; in IDLE it may still carry the
    // previous frame's last word, which moves to O as the next word0 arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            h_q     <= '0;
            o_q     <= '0;
        end else if (accept) begin
            unique case (state_q)
                IDLE: begin
                    o_q     <= h_q;
                    h_q     <= '{valid: 1'b1, data: input_axis.tdata, keep: input_axis.tkeep,
                                 last: input_axis.tlast, user: input_axis.tlast};
                    state_q <= input_axis.tlast ? IDLE : HDR1;
                end
                HDR1: begin
                    if (hdr_ok) begin
                        o_q <= '{valid: 1'b1, data: swp_w0, keep: h_q.keep, last: 1'b0, user: 1'b0};
                        h_q <= '{valid: 1'b1, data: swp_w1, keep: input_axis.tkeep,
                                 last: input_axis.tlast,
                                 user: input_axis.tuser & input_axis.tlast};
                    end else begin
                        // Fewer than 12 bytes: no complete src MAC, forward untouched and flag.
                        o_q <= h_q;
                        h_q <= '{valid: 1'b1, data: input_axis.tdata, keep: input_axis.tkeep,
                                 last: input_axis.tlast, user: input_axis.tlast};
                    end
                    state_q <= input_axis.tlast ? IDLE : BODY;
                end
                default: begin
                    o_q     <= h_q;
                    h_q     <= '{valid: 1'b1, data: input_axis.tdata, keep: input_axis.tkeep,
                                 last: input_axis.tlast,
                                 user: input_axis.tuser & input_axis.tlast};
                    state_q <= input_axis.tlast ? IDLE : BODY;
                end
            endcase
        end else if (slot_free) begin
            if (h_q.valid && h_q.last) begin
                o_q       <= h_q;
                h_q.valid <= 1'b0;
            end else begin
                o_q.valid <= 1'b0;
            end
        end
    end

    assign output_axis.tvalid = o_q.valid;
    assign output_axis.tdata  = o_q.data;
    assign output_axis.tkeep  = o_q.keep;
    assign output_axis.tlast  = o_q.last;
    assign output_axis.tuser  = o_q.user;

`ifdef ETH_MAC_SWAP_CNT_EN
    logic [31:0] frame_count_q;
    logic [15:0] short_count_q;
    logic        short_inc;
    logic        frame_inc;

    assign short_inc = accept && input_axis.tlast &&
                       ((state_q == IDLE) || ((state_q == HDR1) && !hdr_ok));
    assign frame_inc = o_q.valid && output_axis.tready && o_q.last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count_q <= '0;
            short_count_q <= '0;
        end else begin
            if (frame_inc) frame_count_q <= frame_count_q + 32'd1;
            if (short_inc) short_count_q <= short_count_q + 16'd1;
        end
    end

    assign frame_count = frame_count_q;
    assign short_count = short_count_q;
`endif

endmodule

// File: tb/tb_eth_mac_swap_64.sv
// tb/tb_eth_mac_swap_64.sv - scoreboard bench for eth_mac_swap_64
module tb_eth_mac_swap_64;
    import eth_swap_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    eth_mac_swap_64_if in_if ();
    eth_mac_swap_64_if out_if ();

`ifdef ETH_MAC_SWAP_CNT_EN
    logic [31:0] frame_count;
    logic [15:0] short_count;
`endif

    eth_mac_swap_64 #(.ENABLE_SWAP(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .input_axis  (in_if),
        .output_axis (out_if)
`ifdef ETH_MAC_SWAP_CNT_EN
        ,
        .frame_count (frame_count),
        .short_count (short_count)
`endif
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] fbuf [0:255];
    int         flen = 0;
    int         ready_mode = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic make_frame(input int len, input logic [7:0] dlsb, input logic [7:0] slsb);
        flen = len;
        for (int i = 0; i < 256; i++) fbuf[i] = 8'(i) ^ 8'h5A;
        fbuf[0] = 8'h02; fbuf[1] = 8'h00; fbuf[2] = 8'h00;
        fbuf[3] = 8'h00; fbuf[4] = 8'h00; fbuf[5] = dlsb;
        fbuf[6] = 8'h02; fbuf[7] = 8'h00; fbuf[8] = 8'h00;
        fbuf[9] = 8'h00; fbuf[10] = 8'h00; fbuf[11] = slsb;
    endtask

    // Reference: whole-frame byte exchange of bytes 0-5 with 6-11 for frames of 12+ bytes.
    task automatic push_expected(input bit user_last);
        logic [7:0] mbuf [0:255];
        bit   short_f;
        int   nw;
        exp_t e;
        for (int i = 0; i < 256; i++) mbuf[i] = fbuf[i];
        short_f = (flen < 12);
        if (!short_f) begin
            for (int i = 0; i < 6; i++) begin
                mbuf[i]     = fbuf[i + 6];
                mbuf[i + 6] = fbuf[i];
            end
        end
        nw = (flen + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            e.data = '0;
            e.keep = '0;
            for (int b = 0; b < 8; b++) begin
                if (w * 8 + b < flen) begin
                    e.data[8*b +: 8] = mbuf[w*8 + b];
                    e.keep[b]        = 1'b1;
                end
            end
            e.last = (w == nw - 1);
            e.user = e.last & (user_last | short_f);
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_word(input int w, input bit user_last);
        int nw;
        nw = (flen + 7) / 8;
        in_if.tdata = '0;
        in_if.tkeep = '0;
        for (int b = 0; b < 8; b++) begin
            if (w * 8 + b < flen) begin
                in_if.tdata[8*b +: 8] = fbuf[w*8 + b];
                in_if.tkeep[b]        = 1'b1;
            end
        end
        in_if.tlast  = (w == nw - 1);
        in_if.tuser  = (w == nw - 1) & user_last;
        in_if.tvalid = 1'b1;
    endtask

    task automatic send_frame(input bit user_last);
        int  nw;
        int  t;
        bit  acc;
        push_expected(user_last);
        nw = (flen + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            drive_word(w, user_last);
            t = 0;
            acc = 1'b0;
            while (!acc && t < 1000) begin
                @(negedge clk);
                acc = in_if.tready;
                @(posedge clk);
                #1;
                t++;
            end
            if (!acc) check("in_accept_timeout", 64'd0, 64'd1);
        end
        in_if.tvalid = 1'b0;
        in_if.tlast  = 1'b0;
        in_if.tuser  = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        check({tag, "_drain_left"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_idle_tvalid"}, 64'(out_if.tvalid), 64'd0);
    endtask

    task automatic apply_reset();
        in_if.tvalid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_tvalid", 64'(out_if.tvalid), 64'd0);
        check("rst_tdata", out_if.tdata, 64'd0);
        check("rst_tkeep", 64'(out_if.tkeep), 64'd0);
        check("rst_tlast_tuser", {62'd0, out_if.tlast, out_if.tuser}, 64'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Output monitor: a transfer seen at the negedge completes on the following posedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_if.tvalid && out_if.tready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_word", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_tdata", out_if.tdata, e.data);
                    check("out_tkeep", 64'(out_if.tkeep), 64'(e.keep));
                    check("out_tlast", 64'(out_if.tlast), 64'(e.last));
                    check("out_tuser", 64'(out_if.tuser), 64'(e.user));
                end
            end
        end
    end

    initial begin
        out_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) out_if.tready = 1'b1;
            else                 out_if.tready = ~out_if.tready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout observed running expected finished");
        $fatal(1);
    end

    initial begin
        time t0;
        in_if.tvalid = 1'b0;
        in_if.tdata  = '0;
        in_if.tkeep  = '0;
        in_if.tlast  = 1'b0;
        in_if.tuser  = 1'b0;

        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("reset_tvalid", 64'(out_if.tvalid), 64'd0);
        check("reset_tdata", out_if.tdata, 64'd0);
        check("reset_in_tready", 64'(in_if.tready), 64'd1);
`ifdef ETH_MAC_SWAP_CNT_EN
        check("reset_frame_count", 64'(frame_count), 64'd0);
        check("reset_short_count", 64'(short_count), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 64-byte frame, ready high: full rate, swapped header.
        make_frame(64, 8'h01, 8'h02);
        t0 = $time;
        send_frame(1'b0);
        check("t64_accept_cycles", 64'(($time - t0) / 10), 64'd8);
        wait_drain("t64");

        // Same frame with output ready toggling every cycle.
        ready_mode = 1;
        make_frame(64, 8'h01, 8'h02);
        send_frame(1'b0);
        wait_drain("t64_toggle");
        ready_mode = 0;
        @(posedge clk);
        #1;

        // Reset in the middle of a frame's body.
        make_frame(64, 8'h01, 8'h02);
        push_expected(1'b0);
        for (int w = 0; w < 4; w++) begin
            drive_word(w, 1'b0);
            @(posedge clk);
            #1;
            if (w == 0) check("word0_no_output", 64'(out_if.tvalid), 64'd0);
            if (w == 1) check("word1_latency", 64'(out_if.tvalid), 64'd1);
        end
        apply_reset();
        make_frame(64, 8'h01, 8'h02);
        send_frame(1'b0);
        wait_drain("t_after_reset");

        // Single-word 8-byte frame.
        make_frame(8, 8'h11, 8'h22);
        send_frame(1'b0);
        wait_drain("t8_single");
`ifdef ETH_MAC_SWAP_CNT_EN
        check("t8_short_count", 64'(short_count), 64'd1);
`endif

        // 10, 11 and 12 byte boundaries.
        make_frame(10, 8'h33, 8'h44);
        send_frame(1'b0);
        wait_drain("t10");
        make_frame(11, 8'h35, 8'h46);
        send_frame(1'b0);
        wait_drain("t11");
        make_frame(12, 8'h55, 8'h66);
        send_frame(1'b0);
        wait_drain("t12");

        // Mixed lengths back-to-back under toggling ready.
        ready_mode = 1;
        for (int i = 0; i < 6; i++) begin
            make_frame($urandom_range(40, 9), 8'(i), 8'(i + 8'h80));
            send_frame(i[0]);
        end
        wait_drain("t_mixed");
        ready_mode = 0;
        @(posedge clk);
        #1;

        // Back-to-back 64-byte frames, tuser on the first frame's last word.
        apply_reset();
        make_frame(64, 8'h01, 8'h02);
        send_frame(1'b1);
        make_frame(64, 8'h01, 8'h02);
        send_frame(1'b0);
        wait_drain("t_b2b");
`ifdef ETH_MAC_SWAP_CNT_EN
        check("b2b_frame_count", 64'(frame_count), 64'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_mac_swap_64.md
ETH_MAC_SWAP_64 -- requirements
Module: eth_mac_swap_64

Interface
REQ-001 SHALL have parameter: ENABLE_SWAP, default 1, 1 = exchange destination/source MAC, 0 = pass frames unmodified through the same pipeline.
REQ-002 SHALL have port: clk  input  1  single clock for all logic.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports: input_axis_tdata input 64, tkeep input 8, tvalid input 1, tready output 1, tlast input 1, tuser input 1; AXI-stream frames received from the 10G MAC FIFO.
REQ-005 SHALL have ports: output_axis_tdata output 64, tkeep output 8, tvalid output 1, tready input 1, tlast output 1, tuser output 1; AXI-stream frames toward the 10G MAC TX FIFO.
REQ-006 SHALL use the byte order tdata[8*i+7:8*i] = frame byte i of the current word, with tkeep[i] marking it valid.

Function
REQ-007 SHALL implement a two-word pipeline: hold register H (one word, original data) and output register O (one word).
REQ-008 SHALL run a state machine with states IDLE (next word is word0), HDR1 (word0 in H, expecting word1) and BODY (words 2..n).
REQ-009 SHALL set input_axis_tready = !O.valid || output_axis_tready; a word transfers on tvalid && tready.
REQ-010 SHALL, in IDLE on a non-last word, load H and go to HDR1 without loading O.
REQ-011 SHALL, in HDR1 on a word whose tkeep[3:0]==4'hF, load O with out-word0 = {W0 bytes 0-1 in bytes 6-7, W1 bytes 0-3 in bytes 2-5, W0 bytes 6-7 in bytes 0-1}, load H with W1 bytes 0-3 replaced by W0 bytes 2-5, and go to BODY (or IDLE if last).
REQ-012 SHALL, in BODY, on each accepted word, move H to O and load the new word into H; on tlast, move H to O, then emit the final word from H on the next free slot before accepting the next frame, and return to IDLE.
REQ-013 SHALL treat a frame ending in IDLE (single word) or ending in HDR1 with tkeep[3:0]!=4'hF (< 12 bytes) as short: forwarded unmodified, output_axis_tuser=1 on its last word.
REQ-014 SHALL propagate input tuser of the last input word to the last output word (OR-ed with the short flag); tkeep and tlast SHALL travel with their word.
REQ-015 SHALL sustain one word per cycle with output_axis_tready held high; latency from word1 acceptance to out-word0 valid is 1 cycle.
REQ-016 SHALL hold O stable (data, keep, last, user) while output_axis_tvalid=1 and output_axis_tready=0.
REQ-017 SHALL bypass the byte exchange when ENABLE_SWAP=0, keeping identical timing.

Reset
REQ-018 SHALL, on rst_n low, immediately clear O.valid, H.valid and output_axis_tvalid to 0, output_axis_tdata/tkeep/tlast/tuser to 0, and state to IDLE.
REQ-019 SHALL discard any partial frame held at reset; the first word after rst_n rises is treated as word0.

Configuration
REQ-020 SHALL, with ETH_MAC_SWAP_CNT_EN defined, add outputs frame_count[31:0] (frames completed on output) and short_count[15:0] (short frames), both wrapping, reset to 0.
REQ-021 SHALL, without ETH_MAC_SWAP_CNT_EN, omit those ports and counter logic entirely.

Structure
REQ-022 SHALL take the state encoding (IDLE/HDR1/BODY) and byte offsets (DST_OFS=0, SRC_OFS=6, MAC_LEN=6) from shared package eth_swap_pkg.
REQ-023 SHALL contain one sub-module eth_mac_swap_bytes (combinational word0/word1 remap) instantiated once.

Verification
REQ-024 SHALL cover: 64-byte frame, dst 02:00:00:00:00:01, src 02:00:00:00:00:02, ready high -> output dst 02:..:02, src 02:..:01, 8 words, bytes 12-63 identical, tuser=0.
REQ-025 SHALL cover: same frame with output_axis_tready toggling 1/0 each cycle -> identical output content, no word dropped or duplicated.
REQ-026 SHALL cover: 8-byte single-word frame (tkeep=8'hFF, tlast=1) -> forwarded unchanged, tuser=1, short_count=1.
REQ-027 SHALL cover: 10-byte frame (word1 tkeep=8'h03) -> unchanged, tuser=1 on word1.
REQ-028 SHALL cover: rst_n low asserted while in BODY of a frame -> output_axis_tvalid=0 same cycle; next 64-byte frame swapped correctly.
REQ-029 SHALL cover: back-to-back 64-byte frames with input tuser=1 on the first frame's last word -> first frame tuser=1, second 0, frame_count=2.
